// File: rtl/wt_cache_pkg.sv
// Shared types and derived sizes for the WT dcache refill path.
// Defaults follow the configured 128-bit line / 64-bit bus.
package wt_cache_pkg;

    localparam int unsigned CFG_LINE_WIDTH = 128;
    localparam int unsigned CFG_BEAT_WIDTH = 64;
    localparam int unsigned NUM_BEATS      = CFG_LINE_WIDTH / CFG_BEAT_WIDTH;
    localparam int unsigned IDX_W          = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic [1:0] {
        REFILL_IDLE  = 2'd0,
        REFILL_FILL  = 2'd1,
        REFILL_DRAIN = 2'd2
    } refill_state_e;

endpackage

// File: rtl/wt_refill_beat_slot_wr.sv
// Decodes the current write index into one-hot write enables for the
// beat slots of the line register.
module wt_refill_beat_slot_wr #(
    parameter int unsigned NUM_BEATS = 2,
    parameter int unsigned IDX_W     = 1
) (
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    output logic [NUM_BEATS-1:0] slot_we_o
);

    always_comb begin
        slot_we_o = '0;
        for (int k = 0; k < NUM_BEATS; k++) begin
            slot_we_o[k] = wr_en_i && (wr_idx_i == IDX_W'(k));
        end
    end

endmodule

// File: rtl/wt_dcache_refill_assembler.sv
// Collects critical-word-first refill beats into a line-aligned cacheline,
// forwards the critical beat early and hands the line to the fill port.
module wt_dcache_refill_assembler #(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned BEAT_WIDTH = 64,
    parameter int unsigned TID_WIDTH  = 2,
    localparam int unsigned NUM_BEATS = LINE_WIDTH / BEAT_WIDTH,
    localparam int unsigned IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [TID_WIDTH-1:0]  req_tid_i,
    input  logic [IDX_W-1:0]      req_beat_idx_i,
    input  logic                  beat_valid_i,
    output logic                  beat_ready_o,
    input  logic [TID_WIDTH-1:0]  beat_tid_i,
    input  logic [BEAT_WIDTH-1:0] beat_data_i,
    input  logic                  beat_err_i,
    output logic                  crit_valid_o,
    output logic [BEAT_WIDTH-1:0] crit_data_o,
    output logic                  line_valid_o,
    input  logic                  line_ready_i,
    output logic [LINE_WIDTH-1:0] line_data_o,
    output logic [TID_WIDTH-1:0]  line_tid_o,
    output logic                  line_err_o,
    output logic                  busy_o
);

    import wt_cache_pkg::*;

    refill_state_e         state_q, state_d;
    logic [TID_WIDTH-1:0]  tid_q, tid_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  crit_valid_q, crit_valid_d;
    logic [BEAT_WIDTH-1:0] crit_data_q, crit_data_d;
    logic [LINE_WIDTH-1:0] line_q;
    logic                  beat_wr_en;
    logic [NUM_BEATS-1:0]  slot_we;

    wt_refill_beat_slot_wr #(
        .NUM_BEATS (NUM_BEATS),
        .IDX_W     (IDX_W)
    ) i_slot_wr (
        .wr_en_i   (beat_wr_en),
        .wr_idx_i  (wr_idx_q),
        .slot_we_o (slot_we)
    );

    always_comb begin
        state_d      = state_q;
        tid_d        = tid_q;
        wr_idx_d     = wr_idx_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        beat_wr_en   = 1'b0;
        req_ready_o  = 1'b0;
        beat_ready_o = 1'b0;
        line_valid_o = 1'b0;

        case (state_q)
            REFILL_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    tid_d    = req_tid_i;
                    wr_idx_d = req_beat_idx_i;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = REFILL_FILL;
                end
            end
            REFILL_FILL: begin
                beat_ready_o = 1'b1;
                if (beat_valid_i) begin
                    if (beat_tid_i == tid_q) begin
                        beat_wr_en = 1'b1;
                        wr_idx_d   = wr_idx_q + IDX_W'(1);
                        cnt_d      = cnt_q + IDX_W'(1);
                        err_d      = err_q | beat_err_i;
                        if (cnt_q == '0) begin
                            crit_valid_d = 1'b1;
                            crit_data_d  = beat_data_i;
                        end
                        if (cnt_q == IDX_W'(NUM_BEATS - 1)) begin
                            state_d = REFILL_DRAIN;
                        end
                    end else begin
                        // Stray beat from another transaction: swallow it, flag the line.
                        err_d = 1'b1;
                    end
                end
            end
            REFILL_DRAIN: begin
                line_valid_o = 1'b1;
                if (line_ready_i) begin
                    state_d = REFILL_IDLE;
                end
            end
            default: state_d = REFILL_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= REFILL_IDLE;
            tid_q        <= '0;
            wr_idx_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            tid_q        <= tid_d;
            wr_idx_q     <= wr_idx_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            for (int k = 0; k < NUM_BEATS; k++) begin
                if (slot_we[k]) begin
                    line_q[k*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data_i;
                end
            end
        end
    end

    assign crit_valid_o = crit_valid_q;
    assign crit_data_o  = crit_data_q;
    assign line_data_o  = line_q;
    assign line_tid_o   = tid_q;
    assign line_err_o   = err_q;
    assign busy_o       = (state_q != REFILL_IDLE);

endmodule

// File: tb/tb_wt_dcache_refill_assembler.sv
// Directed bench for the refill assembler: a 128/64 instance (A) and a
// 256/64 instance (B) share clock, reset and the beat bus.
module tb_wt_dcache_refill_assembler;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_req_valid, b_req_valid;
    logic [1:0]   req_tid;
    logic [0:0]   a_idx;
    logic [1:0]   b_idx;
    logic         beat_valid;
    logic [1:0]   beat_tid;
    logic [63:0]  beat_data;
    logic         beat_err;
    logic         line_ready;

    logic         a_req_ready, a_beat_ready, a_crit_valid, a_line_valid, a_line_err, a_busy;
    logic [63:0]  a_crit_data;
    logic [127:0] a_line_data;
    logic [1:0]   a_line_tid;
    logic         b_req_ready, b_beat_ready, b_crit_valid, b_line_valid, b_line_err, b_busy;
    logic [63:0]  b_crit_data;
    logic [255:0] b_line_data;
    logic [1:0]   b_line_tid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wt_dcache_refill_assembler #(.LINE_WIDTH(128), .BEAT_WIDTH(64), .TID_WIDTH(2)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
        .req_tid_i(req_tid), .req_beat_idx_i(a_idx),
        .beat_valid_i(beat_valid), .beat_ready_o(a_beat_ready),
        .beat_tid_i(beat_tid), .beat_data_i(beat_data), .beat_err_i(beat_err),
        .crit_valid_o(a_crit_valid), .crit_data_o(a_crit_data),
        .line_valid_o(a_line_valid), .line_ready_i(line_ready),
        .line_data_o(a_line_data), .line_tid_o(a_line_tid),
        .line_err_o(a_line_err), .busy_o(a_busy)
    );

    wt_dcache_refill_assembler #(.LINE_WIDTH(256), .BEAT_WIDTH(64), .TID_WIDTH(2)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_tid_i(req_tid), .req_beat_idx_i(b_idx),
        .beat_valid_i(beat_valid), .beat_ready_o(b_beat_ready),
        .beat_tid_i(beat_tid), .beat_data_i(beat_data), .beat_err_i(beat_err),
        .crit_valid_o(b_crit_valid), .crit_data_o(b_crit_data),
        .line_valid_o(b_line_valid), .line_ready_i(line_ready),
        .line_data_o(b_line_data), .line_tid_o(b_line_tid),
        .line_err_o(b_line_err), .busy_o(b_busy)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic req_a(input logic [1:0] tid, input logic idx);
        a_req_valid = 1'b1; req_tid = tid; a_idx = idx;
        @(negedge clk);
        a_req_valid = 1'b0;
    endtask

    task automatic req_b(input logic [1:0] tid, input logic [1:0] idx);
        b_req_valid = 1'b1; req_tid = tid; b_idx = idx;
        @(negedge clk);
        b_req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] tid, input logic [63:0] data, input logic err);
        beat_valid = 1'b1; beat_tid = tid; beat_data = data; beat_err = err;
        @(negedge clk);
        beat_valid = 1'b0; beat_err = 1'b0;
    endtask

    task automatic handshake_a();
        line_ready = 1'b1;
        @(negedge clk);
        line_ready = 1'b0;
        check("handoff_valid_drop", {255'd0, a_line_valid}, 256'd0);
        check("handoff_req_ready", {255'd0, a_req_ready}, 256'd1);
    endtask

    initial begin
        rst = 1'b1; a_req_valid = 1'b0; b_req_valid = 1'b0; req_tid = '0; a_idx = '0; b_idx = '0;
        beat_valid = 1'b0; beat_tid = '0; beat_data = '0; beat_err = 1'b0; line_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_req_ready", {255'd0, a_req_ready}, 256'd1);
        check("rst_busy", {255'd0, a_busy}, 256'd0);
        check("rst_line_valid", {255'd0, a_line_valid}, 256'd0);
        check("rst_crit_valid", {255'd0, a_crit_valid}, 256'd0);
        check("rst_line_data", {128'd0, a_line_data}, 256'd0);
        check("rst_beat_ready", {255'd0, a_beat_ready}, 256'd0);

        // Aligned refill
        req_a(2'd1, 1'b0);
        check("al_busy", {255'd0, a_busy}, 256'd1);
        check("al_beat_ready", {255'd0, a_beat_ready}, 256'd1);
        check("al_req_ready", {255'd0, a_req_ready}, 256'd0);
        send_beat(2'd1, 64'h1111, 1'b0);
        check("al_crit_valid", {255'd0, a_crit_valid}, 256'd1);
        check("al_crit_data", {192'd0, a_crit_data}, 256'h1111);
        check("al_line_early", {255'd0, a_line_valid}, 256'd0);
        send_beat(2'd1, 64'h2222, 1'b0);
        check("al_line_valid", {255'd0, a_line_valid}, 256'd1);
        check("al_crit_drop", {255'd0, a_crit_valid}, 256'd0);
        check("al_line_data", {128'd0, a_line_data}, {128'd0, 64'h2222, 64'h1111});
        check("al_line_tid", {254'd0, a_line_tid}, 256'd1);
        check("al_line_err", {255'd0, a_line_err}, 256'd0);
        check("al_drain_beat_ready", {255'd0, a_beat_ready}, 256'd0);
        handshake_a();
        check("al_crit_hold", {192'd0, a_crit_data}, 256'h1111);

        // Critical-word-first wrap
        req_a(2'd0, 1'b1);
        send_beat(2'd0, 64'hAAAA, 1'b0);
        check("wr_crit_data", {192'd0, a_crit_data}, 256'hAAAA);
        send_beat(2'd0, 64'hBBBB, 1'b0);
        check("wr_line_data", {128'd0, a_line_data}, {128'd0, 64'hAAAA, 64'hBBBB});
        check("wr_line_tid", {254'd0, a_line_tid}, 256'd0);
        handshake_a();

        // Error on the second beat
        req_a(2'd3, 1'b0);
        send_beat(2'd3, 64'h0C01, 1'b0);
        send_beat(2'd3, 64'h0C02, 1'b1);
        check("er_line_valid", {255'd0, a_line_valid}, 256'd1);
        check("er_line_err", {255'd0, a_line_err}, 256'd1);
        check("er_line_data", {128'd0, a_line_data}, {128'd0, 64'h0C02, 64'h0C01});
        handshake_a();

        // Stray tid interleaved
        req_a(2'd2, 1'b0);
        send_beat(2'd2, 64'h0005, 1'b0);
        send_beat(2'd3, 64'hDEAD, 1'b0);
        check("st_no_line", {255'd0, a_line_valid}, 256'd0);
        check("st_still_busy", {255'd0, a_beat_ready}, 256'd1);
        send_beat(2'd2, 64'h0006, 1'b0);
        check("st_line_valid", {255'd0, a_line_valid}, 256'd1);
        check("st_line_data", {128'd0, a_line_data}, {128'd0, 64'h0006, 64'h0005});
        check("st_line_err", {255'd0, a_line_err}, 256'd1);
        check("st_line_tid", {254'd0, a_line_tid}, 256'd2);
        handshake_a();

        // Backpressure; a request during DRAIN must be ignored
        req_a(2'd1, 1'b0);
        send_beat(2'd1, 64'h7001, 1'b0);
        send_beat(2'd1, 64'h7002, 1'b0);
        a_req_valid = 1'b1; req_tid = 2'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_line_valid", {255'd0, a_line_valid}, 256'd1);
            check("bp_line_data", {128'd0, a_line_data}, {128'd0, 64'h7002, 64'h7001});
            check("bp_ready_flags", {254'd0, a_beat_ready, a_req_ready}, 256'd0);
        end
        a_req_valid = 1'b0;
        check("bp_line_tid", {254'd0, a_line_tid}, 256'd1);
        handshake_a();

        // Reset in the middle of FILL
        req_a(2'd1, 1'b0);
        send_beat(2'd1, 64'h9999, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_busy", {255'd0, a_busy}, 256'd0);
        check("mr_req_ready", {255'd0, a_req_ready}, 256'd1);
        check("mr_crit_data", {192'd0, a_crit_data}, 256'd0);
        repeat (3) begin
            @(negedge clk);
            check("mr_no_pulse", {254'd0, a_crit_valid, a_line_valid}, 256'd0);
        end
        req_a(2'd1, 1'b0);
        send_beat(2'd1, 64'h1111, 1'b0);
        check("mr_crit_data2", {192'd0, a_crit_data}, 256'h1111);
        send_beat(2'd1, 64'h2222, 1'b0);
        check("mr_line_data", {128'd0, a_line_data}, {128'd0, 64'h2222, 64'h1111});
        handshake_a();

        // 4-beat line, critical beat 3: slots filled in order 3,0,1,2
        req_b(2'd1, 2'd3);
        check("b_busy", {255'd0, b_busy}, 256'd1);
        send_beat(2'd1, 64'h30, 1'b0);
        check("b_crit_valid", {255'd0, b_crit_valid}, 256'd1);
        check("b_crit_data", {192'd0, b_crit_data}, 256'h30);
        send_beat(2'd1, 64'h31, 1'b0);
        send_beat(2'd1, 64'h32, 1'b0);
        check("b_line_early", {255'd0, b_line_valid}, 256'd0);
        send_beat(2'd1, 64'h33, 1'b0);
        check("b_line_valid", {255'd0, b_line_valid}, 256'd1);
        check("b_line_data", b_line_data, {64'h30, 64'h33, 64'h32, 64'h31});
        check("b_line_err", {255'd0, b_line_err}, 256'd0);
        check("a_untouched", {255'd0, a_busy}, 256'd0);
        line_ready = 1'b1;
        @(negedge clk);
        line_ready = 1'b0;
        check("b_handoff", {254'd0, b_line_valid, b_req_ready}, 256'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wt_dcache_refill_assembler.md
Name: wt_dcache_refill_assembler

Overview:
- Sits between the L1 data-cache memory-response path and the WT dcache line-fill logic.
- Collects the BEAT_WIDTH-bit response beats of one outstanding refill. Beats arrive critical-word-first and wrap around the line.
- Forwards the critical beat early to the load unit.
- Presents the assembled, line-aligned LINE_WIDTH-bit cacheline to the fill port with a valid/ready handshake.
- Handles one refill at a time; the upstream miss unit does not issue a new refill until the line is accepted.

Parameters:
- LINE_WIDTH, 128, cacheline width in bits (CVA6ConfigDcacheLineWidth).
- BEAT_WIDTH, 64, response beat width in bits (CVA6ConfigAxiDataWidth). LINE_WIDTH is a power-of-2 multiple of BEAT_WIDTH, ratio >= 2.
- TID_WIDTH, 2, memory transaction ID width (CVA6ConfigMemTidWidth).
- NUM_BEATS, LINE_WIDTH/BEAT_WIDTH, derived (localparam).
- IDX_W, max(1,$clog2(NUM_BEATS)), derived beat-index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  new refill announced
- req_ready_o  out  1  assembler idle, can accept a refill
- req_tid_i  in  TID_WIDTH  refill transaction ID
- req_beat_idx_i  in  IDX_W  index of the critical (first-returned) beat
- beat_valid_i  in  1  response beat valid
- beat_ready_o  out  1  beat accepted
- beat_tid_i  in  TID_WIDTH  beat transaction ID
- beat_data_i  in  BEAT_WIDTH  beat payload
- beat_err_i  in  1  bus error on this beat
- crit_valid_o  out  1  one-cycle pulse: critical beat available
- crit_data_o  out  BEAT_WIDTH  critical beat payload
- line_valid_o  out  1  assembled line ready
- line_ready_i  in  1  fill port accepts line
- line_data_o  out  LINE_WIDTH  line-aligned data; beat k at bits [k*BEAT_WIDTH +: BEAT_WIDTH]
- line_tid_o  out  TID_WIDTH  ID of the assembled line
- line_err_o  out  1  any beat errored or was malformed
- busy_o  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, FILL, DRAIN.
- Reset: state=IDLE; all outputs 0 except req_ready_o=1; line buffer cleared; beat counter=0; error flag=0. Reset in any state aborts the refill with no output pulse.
- IDLE:
  - req_ready_o=1, beat_ready_o=0.
  - On req_valid_i: latch tid and start index; wr_idx=req_beat_idx_i; cnt=0; err=0; go to FILL.
- FILL:
  - beat_ready_o=1, req_ready_o=0.
  - On beat_valid_i with beat_tid_i==latched tid: write beat_data_i at slot wr_idx; wr_idx=wr_idx+1 mod NUM_BEATS (wraps naturally in IDX_W bits); cnt+1; err|=beat_err_i.
  - First accepted beat (cnt==0): crit_valid_o=1 in the following cycle, crit_data_o=that beat; crit_data_o holds until the next refill.
  - Beat with mismatched tid: accepted (ready=1) and discarded; sets err; cnt is not incremented.
  - When cnt reaches NUM_BEATS-1 and a valid beat is accepted: go to DRAIN next cycle.
- DRAIN:
  - line_valid_o=1; line_data_o, line_tid_o, line_err_o stable.
  - beat_ready_o=0.
  - On line_ready_i: go to IDLE; line_valid_o drops the next cycle.
- Latency:
  - Last beat accepted in cycle N gives line_valid_o in cycle N+1.
  - Handoff takes 1 cycle when line_ready_i is already high.
  - Earliest new req_ready_o=1 is the cycle after the handshake.
- req_valid_i outside IDLE is ignored; req_ready_o=0 there.
- Single beat with err: the line still completes; line_err_o=1.
- crit_valid_o and line_valid_o cannot be high together when NUM_BEATS>=2.

Decomposition:
- Shared package wt_cache_pkg:
  - refill state enum.
  - Localparams NUM_BEATS and IDX_W derived from the cva6_cfg line and bus widths.
- One sub-module is natural: wt_refill_beat_slot_wr. It decodes wr_idx and write-enables the beat slots of the line register.

Test Plan:
- Aligned refill, 128/64: req tid=1, idx=0; beats A=0x1111, B=0x2222 -> crit pulse with 0x1111; line_data_o = {0x2222,0x1111} (B in upper 64 bits, A in lower), tid=1, err=0, valid one cycle after B.
- Critical-word-first wrap: idx=1; beats A then B -> crit=A; line = {A,B}.
- Error beat: second beat has beat_err_i=1 -> line completes, line_err_o=1.
- Stray tid: tid=2 refill, interleaved beat with tid=3 -> discarded, cnt unchanged, line_err_o=1, data slots unaffected.
- Backpressure: line_ready_i low 5 cycles -> line_valid_o and data held, beat_ready_o=0, req_ready_o=0; release -> IDLE, req_ready_o=1 next cycle.
- Reset mid-FILL after 1 beat -> IDLE, no crit/line pulse afterwards, next refill assembles correctly. Also repeat the aligned scenario with LINE_WIDTH=256, BEAT_WIDTH=64, idx=3: correct 4-beat wrap order 3,0,1,2.
